// File: rtl/conv3x3_window_sched.sv
// Raster-scan 3x3 window scheduler: two line buffers build windows, results are collected in a credit-managed FIFO.
// Latency: pixel completing a window -> result at FIFO head after the datapath's one-clock register (3 cycles).
// Backpressure: pix_ready drops when FIFO entries plus in-flight windows reach FIFO_DEPTH; out_ready stalls the FIFO head.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   start, cfg_width, cfg_height frame start pulse and frame size (sampled on start)
//   busy, done, cfg_err          frame status: busy level, done pulse, rejected-config pulse
//   pix_valid/pix_ready/pix_data input pixel stream, raster order
//   patch, conv_result           window to datapath, registered result one clock later
//   out_valid/out_ready          result stream handshake
//   out_pixel, out_last          result data and end-of-frame marker
module conv3x3_window_sched #(
  parameter int MAX_W      = 64,
  parameter int DIM_BITS   = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DIM_BITS-1:0] cfg_width,
  input  logic [DIM_BITS-1:0] cfg_height,
  output logic                busy,
  output logic                done,
  output logic                cfg_err,
  input  logic                pix_valid,
  output logic                pix_ready,
  input  logic [7:0]          pix_data,
  output logic [71:0]         patch,
  input  logic [9:0]          conv_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [9:0]          out_pixel,
  output logic                out_last
);

  localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t              state_q;
  logic [DIM_BITS-1:0] w_q, h_q, x_q, y_q;
  logic [71:0]         win_q, win_d;
  logic                s1_q, s2_q, last1_q, last2_q;
  logic                busy_q, done_q, cfg_err_q;

  logic [7:0]          lb0_q [MAX_W];
  logic [7:0]          lb1_q [MAX_W];

  logic [10:0]         mem_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       cnt_q;

  logic [AW-1:0]       xa;
  logic [CW+1:0]       credits;
  logic                pix_xfer, x_end, y_end, cfg_ok, push, pop, fifo_idle;
  logic [10:0]         head;

  assign xa = x_q[AW-1:0];

  // Every window in flight (s1/s2) already owns a FIFO slot, so the
  // unconditional push two edges after issue can never overflow.
  assign credits   = {2'b00, cnt_q} + {{(CW+1){1'b0}}, s1_q} + {{(CW+1){1'b0}}, s2_q};
  assign pix_ready = (state_q == S_RUN) && (credits < (CW+2)'(FIFO_DEPTH));
  assign pix_xfer  = pix_valid && pix_ready;

  assign x_end  = (x_q == w_q - DIM_BITS'(1));
  assign y_end  = (y_q == h_q - DIM_BITS'(1));
  assign cfg_ok = (cfg_width >= DIM_BITS'(3)) && (cfg_width <= DIM_BITS'(MAX_W)) &&
                  (cfg_height >= DIM_BITS'(3));

  assign push      = s2_q;
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign head      = mem_q[rd_ptr_q];
  assign out_pixel = out_valid ? head[9:0] : 10'd0;
  assign out_last  = out_valid && head[10];
  assign fifo_idle = !s1_q && !s2_q && (cnt_q == '0);

  assign busy    = busy_q;
  assign done    = done_q;
  assign cfg_err = cfg_err_q;
  assign patch   = win_q;

  // Window shift: columns move left, the new right column is
  // {two rows up, one row up, incoming pixel} with row 0 the oldest.
  always_comb begin
    win_d = win_q;
    if (pix_xfer) begin
      for (int i = 0; i < 3; i++) begin
        win_d[(i*3+0)*8 +: 8] = win_q[(i*3+1)*8 +: 8];
        win_d[(i*3+1)*8 +: 8] = win_q[(i*3+2)*8 +: 8];
      end
      win_d[2*8 +: 8] = lb1_q[xa];
      win_d[5*8 +: 8] = lb0_q[xa];
      win_d[8*8 +: 8] = pix_data;
    end
  end

  // Line buffers carry no reset: rows are overwritten before any
  // issued window can read them.
  always_ff @(posedge clk) begin
    if (pix_xfer) begin
      lb1_q[xa] <= lb0_q[xa];
      lb0_q[xa] <= pix_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      w_q       <= '0;
      h_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      win_q     <= '0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      last1_q   <= 1'b0;
      last2_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      win_q     <= win_d;
      s1_q      <= pix_xfer && (x_q >= DIM_BITS'(2)) && (y_q >= DIM_BITS'(2));
      last1_q   <= pix_xfer && x_end && y_end;
      s2_q      <= s1_q;
      last2_q   <= last1_q;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              state_q <= S_RUN;
              w_q     <= cfg_width;
              h_q     <= cfg_height;
              x_q     <= '0;
              y_q     <= '0;
              busy_q  <= 1'b1;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (pix_xfer) begin
            if (x_end) begin
              x_q <= '0;
              if (y_end) begin
                y_q     <= '0;
                state_q <= S_DRAIN;
              end else begin
                y_q <= y_q + DIM_BITS'(1);
              end
            end else begin
              x_q <= x_q + DIM_BITS'(1);
            end
          end
        end
        S_DRAIN: begin
          if (fifo_idle) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Result FIFO: {last, result}; push/pop in the same cycle keeps the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {last2_q, conv_result};
        wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule
